dcache_direct_mapped: RTL

Direct-mapped, write-through, no-write-allocate data cache between the processor's dcache port (dcache_addr/we/re/din/dout) and the backing memory system in Memory150. Read hits return data one cycle after the request, with the same timing as the CP1 dmem block RAM. Misses and all writes assert cpu_stall, which drives the core's stall input until the memory transaction completes.

---
 rtl/dcache_direct_mapped.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct_mapped
// Brief    : Direct-mapped, write-through, no-write-allocate data cache.
//            A read hit returns its word one cycle after the request, like a
//            block RAM. Misses and all writes stall the core until the
//            backing memory transaction completes.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_direct_mapped #(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  cpu_addr,
    input  logic         cpu_re,
    input  logic [3:0]   cpu_we,
    input  logic [31:0]  cpu_din,
    output logic [31:0]  cpu_dout,
    output logic         cpu_stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rw,
    output logic [27:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    output logic [15:0]  mem_req_mask,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);

    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_req  = 3'd1;
    localparam logic [2:0] c_st_rd_wait = 3'd2;
    localparam logic [2:0] c_st_wr_req  = 3'd3;
    localparam logic [2:0] c_st_resp    = 3'd4;

    logic [2:0]         r_state;
    logic [31:2]        r_req_addr;
    logic [3:0]         r_req_we;
    logic [31:0]        r_req_din;
    logic               r_rd_pend;   // read sampled last edge, tag compare now
    logic [31:0]        r_dout;

    logic [127:0]       r_data  [LINES];
    logic [TAG_W-1:0]   r_tag   [LINES];
    logic [LINES-1:0]   r_valid;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic [127:0]       w_line;
    logic [31:0]        w_hit_word;
    logic               w_hit;
    logic               w_miss_pend;
    logic               w_sample;
    logic               w_smp_rd;
    logic [2:0]         w_smp_state;
    logic               w_wr_accept;
    logic               w_refill;
    logic [15:0]        w_wmask;
    logic [127:0]       w_wdata;
    logic               w_unused_ok;

    // Byte offset bits never matter: the core already lane-shifts data.
    assign w_unused_ok = ^cpu_addr[1:0];

    assign w_idx       = r_req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_tag       = r_req_addr[31:OFFSET_W+INDEX_W];
    assign w_word      = r_req_addr[3:2];
    assign w_line      = r_data[w_idx];
    assign w_hit_word  = w_line[{w_word, 5'b0} +: 32];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss_pend = r_rd_pend && !w_hit;

    // New requests are taken in IDLE (unless the pending read just missed)
    // and in the single RESP cycle that releases the stall.
    assign w_sample    = ((r_state == c_st_idle) && !w_miss_pend) ||
                         (r_state == c_st_resp);
    assign w_smp_rd    = (cpu_we == 4'b0000) && cpu_re;
    assign w_smp_state = (cpu_we != 4'b0000) ? c_st_wr_req : c_st_idle;

    assign w_wr_accept = (r_state == c_st_wr_req) && mem_req_ready;
    assign w_refill    = (r_state == c_st_rd_wait) && mem_resp_valid;

    assign w_wmask     = {12'b0, r_req_we} << {w_word, 2'b00};
    assign w_wdata     = {4{r_req_din}};

    // Control FSM, request capture and read-data holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_req_addr <= '0;
            r_req_we   <= '0;
            r_req_din  <= '0;
            r_rd_pend  <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_sample) begin
                r_req_addr <= cpu_addr[31:2];
                r_req_we   <= cpu_we;
                r_req_din  <= cpu_din;
                r_rd_pend  <= w_smp_rd;
                r_state    <= w_smp_state;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_miss_pend) begin
                        r_state   <= c_st_rd_req;
                        r_rd_pend <= 1'b0;
                    end else if (r_rd_pend) begin
                        r_dout <= w_hit_word;
                    end
                end
                c_st_rd_req: begin
                    if (mem_req_ready) r_state <= c_st_rd_wait;
                end
                c_st_rd_wait: begin
                    if (mem_resp_valid) begin
                        r_dout  <= mem_resp_data[{w_word, 5'b0} +: 32];
                        r_state <= c_st_resp;
                    end
                end
                c_st_wr_req: begin
                    if (mem_req_ready) r_state <= c_st_resp;
                end
                c_st_resp: ;
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Data and tag arrays: line refill on miss, byte-merge on write hit.
    always_ff @(posedge clk) begin
        if (w_refill) begin
            r_data[w_idx] <= mem_resp_data;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_accept && w_hit) begin
            for (int b = 0; b < 16; b++) begin
                if (w_wmask[b]) r_data[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Valid bits: cleared by reset, set only by a completed refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_refill) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    assign cpu_dout      = ((r_state == c_st_idle) && r_rd_pend && w_hit) ?
                           w_hit_word : r_dout;
    assign cpu_stall     = (r_state == c_st_rd_req)  ||
                           (r_state == c_st_rd_wait) ||
                           (r_state == c_st_wr_req)  ||
                           ((r_state == c_st_idle) && w_miss_pend);
    assign mem_req_valid = (r_state == c_st_rd_req) || (r_state == c_st_wr_req);
    assign mem_req_rw    = (r_state == c_st_wr_req);
    assign mem_req_addr  = mem_req_valid ? r_req_addr[31:4] : '0;
    assign mem_req_data  = mem_req_rw ? w_wdata : '0;
    assign mem_req_mask  = mem_req_rw ? w_wmask : '0;

endmodule
`default_nettype wire
